lsu_mem_port: RTL and testbench

- Load/store initiator for the 64-bit doubleword data memory: accepts one load or store per transaction from the core's MEM stage and drives the memory's mem_read/mem_write/addr/write_data port.
- Handles byte/half/word/doubleword sizes: lane extraction and sign/zero extension on loads, read-modify-write for sub-doubleword stores.
- Sits between the execute/MEM pipeline stage and data_memory; the pipeline stalls while req_ready is low.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu_mem_port.sv | 138 +++++++++++++
 tb/tb_lsu_mem_port.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store memory port.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

   // Access size encodings carried on req_size
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   // Transaction sequencer states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } lsu_state_t;

   // Number of bytes touched by an access of the given size (1, 2, 4 or 8)
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

   // An access is misaligned when any offset bit below its natural size is set
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
      logic [2:0] low_mask;
      low_mask = 3'(size_bytes(size) - 4'd1);
      return (offset & low_mask) != 3'b000;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract/extend and sub-doubleword store merge.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [63:0] rdata,
   input  logic [63:0] wdata,
   output logic [63:0] load_data,
   output logic [63:0] store_data
);

   logic [63:0] shifted;
   logic [63:0] wshift;
   logic [7:0]  lane_base;
   logic [7:0]  lane_en;

   // Load path: bring the addressed lane down to bit 0, then truncate and extend
   always_comb begin
      shifted   = rdata >> {offset, 3'b000};
      load_data = shifted;
      case (size)
         SZ_B: load_data = is_unsigned ? {56'd0, shifted[7:0]}
                                       : {{56{shifted[7]}}, shifted[7:0]};
         SZ_H: load_data = is_unsigned ? {48'd0, shifted[15:0]}
                                       : {{48{shifted[15]}}, shifted[15:0]};
         SZ_W: load_data = is_unsigned ? {32'd0, shifted[31:0]}
                                       : {{32{shifted[31]}}, shifted[31:0]};
         default: load_data = shifted;
      endcase
   end

   // Store path: replace only the addressed byte lanes, keep every other lane of rdata
   always_comb begin
      wshift     = wdata << {offset, 3'b000};
      lane_base  = 8'((9'd1 << size_bytes(size)) - 9'd1);
      lane_en    = lane_base << offset;
      store_data = rdata;
      for (int k = 0; k < 8; k++) begin
         if (lane_en[k]) begin
            store_data[8*k +: 8] = wshift[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the MEM stage and the doubleword data memory.
// Latency: misaligned 1, dword store 2, load 3, sub-dword store 4 cycles from accept to rsp_valid.
// Backpressure: req_ready only in IDLE; rsp_valid is a single-cycle pulse with no backpressure.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64   // lane logic is built for 64 only
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   lsu_state_t        state;
   logic              idle_q;      // registered copy of (state == IDLE)
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [2:0]        off_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] store_data;

   // Ready drops immediately while reset is held so nothing is offered during reset
   assign req_ready = idle_q & rst_n;

   lsu_align u_align (
      .offset      (off_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .rdata       (mem_rdata),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .store_data  (store_data)
   );

   // Sequencer: accept in IDLE, walk RD/WAIT/WR as the access needs, finish with one RESP cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idle_q    <= 1'b1;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         we_q      <= 1'b0;
         size_q    <= SZ_B;
         uns_q     <= 1'b0;
         off_q     <= 3'b000;
         wdata_q   <= '0;
      end else begin
         // Strobes and the response pulse are single-cycle unless re-armed below
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  size_q   <= req_size;
                  uns_q    <= req_unsigned;
                  off_q    <= req_addr[2:0];
                  wdata_q  <= req_wdata;
                  mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
                  idle_q   <= 1'b0;
                  if (is_misaligned(req_size, req_addr[2:0])) begin
                     // No memory traffic: report the error straight away
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else if (req_we && (req_size == SZ_D)) begin
                     // Full doubleword store needs no read-modify-write
                     state     <= WR;
                     mem_write <= 1'b1;
                     mem_wdata <= req_wdata;
                  end else begin
                     state    <= RD;
                     mem_read <= 1'b1;
                  end
               end
            end
            RD: begin
               // Memory returns data during the following cycle
               state <= WAIT;
            end
            WAIT: begin
               if (we_q) begin
                  state     <= WR;
                  mem_write <= 1'b1;
                  mem_wdata <= store_data;
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= load_data;
               end
            end
            WR: begin
               state     <= RESP;
               mem_wdata <= '0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            RESP: begin
               state     <= IDLE;
               idle_q    <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            default: begin
               state  <= IDLE;
               idle_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomised scoreboard bench for lsu_mem_port with a byte-array reference memory.
// Latency: expectations carry the cycle count from drive to rsp_valid and to each strobe.
// Backpressure: driver holds req_valid until req_ready is seen.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_err;
   logic [63:0] rsp_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [9:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = '0;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int tot_wr = 0;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      logic [9:0]  addr;
      int          drv;
      int          lat;
      int          n_rd;
      int          n_wr;
      int          rd_off;
      int          wr_off;
      logic [63:0] wr_dat;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  ref_mem [0:1023];
   logic [63:0] dmem [0:127];

   lsu_mem_port #(.ADDR_W(10), .DATA_W(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency bookkeeping
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] init_word(input int i);
      if (i == 2) return 64'h8877665544332211;
      return 64'hA5A5_0000_0000_0000 ^ (64'h9E3779B97F4A7C15 * 64'(i + 1));
   endfunction

   // Data memory: registered read data, zero when not reading
   initial for (int i = 0; i < 128; i++) dmem[i] = init_word(i);
   always @(posedge clk) begin
      mem_rdata <= mem_read ? dmem[mem_addr[9:3]] : 64'd0;
      if (mem_write) dmem[mem_addr[9:3]] = mem_wdata;
   end

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [63:0] ref_dword(input int a);
      logic [63:0] v;
      int base;
      v = 64'd0;
      base = a & ~7;
      for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[base + i]) << (8 * i));
      return v;
   endfunction

   // Reference behaviour: sequential byte-memory semantics evaluated in program order
   function automatic void model_push(input logic we, input logic [1:0] sz, input logic uns,
                                      input logic [9:0] a, input logic [63:0] wd, input int drv);
      exp_t        e;
      logic [63:0] v;
      int          n;
      int          ai;
      n  = 1 << sz;
      ai = int'(a);
      e.addr = {a[9:3], 3'b000};
      e.drv = drv;
      e.rdata = 64'd0;
      e.err = 1'b0;
      e.n_rd = 0;
      e.n_wr = 0;
      e.rd_off = -1;
      e.wr_off = -1;
      e.wr_dat = 64'd0;
      e.lat = 0;
      if ((ai % n) != 0) begin
         e.err = 1'b1;
         e.lat = 1;
      end else if (!we) begin
         v = 64'd0;
         for (int i = 0; i < n; i++) v = v | (64'(ref_mem[ai + i]) << (8 * i));
         if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
         e.rdata = v;
         e.lat = 3;
         e.n_rd = 1;
         e.rd_off = 1;
      end else begin
         for (int i = 0; i < n; i++) ref_mem[ai + i] = wd[8*i +: 8];
         e.wr_dat = ref_dword(ai);
         e.n_wr = 1;
         if (n == 8) begin
            e.lat = 2;
            e.wr_off = 1;
         end else begin
            e.lat = 4;
            e.n_rd = 1;
            e.rd_off = 1;
            e.wr_off = 3;
         end
      end
      exp_q.push_back(e);
   endfunction

   // Monitor: strobe rules every cycle, scoreboard pop on every rsp_valid
   int          n_rd = 0, n_wr = 0, rd_off = -1, wr_off = -1;
   logic [63:0] wr_dat = 64'd0;
   logic        prev_rd = 1'b0, prev_wr = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         n_rd = 0; n_wr = 0; rd_off = -1; wr_off = -1; wr_dat = 64'd0;
         prev_rd = 1'b0; prev_wr = 1'b0;
      end else begin
         check("strobe exclusive", {63'd0, mem_read & mem_write}, 64'd0);
         if (!mem_write) check("mem_wdata idle", mem_wdata, 64'd0);
         if (mem_read) begin
            check("mem_read width", {63'd0, prev_rd}, 64'd0);
            n_rd++;
            if (exp_q.size() > 0) begin
               rd_off = cyc - exp_q[0].drv;
               check("mem_addr on read", 64'(mem_addr), 64'(exp_q[0].addr));
            end
         end
         if (mem_write) begin
            check("mem_write width", {63'd0, prev_wr}, 64'd0);
            n_wr++;
            tot_wr++;
            wr_dat = mem_wdata;
            if (exp_q.size() > 0) begin
               wr_off = cyc - exp_q[0].drv;
               check("mem_addr on write", 64'(mem_addr), 64'(exp_q[0].addr));
            end
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected rsp_valid", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
               check("rsp latency", 64'(cyc - e.drv), 64'(e.lat));
               check("mem_read count", 64'(n_rd), 64'(e.n_rd));
               check("mem_write count", 64'(n_wr), 64'(e.n_wr));
               check("mem_read cycle", 64'(rd_off), 64'(e.rd_off));
               check("mem_write cycle", 64'(wr_off), 64'(e.wr_off));
               check("mem_wdata merged", wr_dat, e.wr_dat);
            end
            n_rd = 0; n_wr = 0; rd_off = -1; wr_off = -1; wr_dat = 64'd0;
         end
         prev_rd = mem_read;
         prev_wr = mem_write;
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [9:0] a, input logic [63:0] wd, input bit track);
      int waited;
      waited = 0;
      @(negedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      while (!req_ready && waited < 40) begin
         @(negedge clk); #1;
         waited++;
      end
      if (!req_ready) begin
         check("req_ready timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
         return;
      end
      if (track) model_push(we, sz, uns, a, wd, cyc);
      @(posedge clk); #1;
      // Garbage on the request bus while busy must be ignored
      req_valid = 1'b0;
      req_we = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3));
      req_addr = 10'($urandom_range(0, 1023));
      req_wdata = {$urandom, $urandom};
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !req_ready) && t < 100) begin
         @(negedge clk); #1;
         t++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int wr_before;
      int n, a;
      logic [1:0] sz;
      for (int w = 0; w < 128; w++)
         for (int b = 0; b < 8; b++) ref_mem[w*8 + b] = init_word(w) >> (8 * b);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("reset req_ready", {63'd0, req_ready}, 64'd0);
      check("reset mem_read", {63'd0, mem_read}, 64'd0);
      check("reset mem_write", {63'd0, mem_write}, 64'd0);
      check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("reset rsp_err", {63'd0, rsp_err}, 64'd0);
      check("reset mem_addr", 64'(mem_addr), 64'd0);
      check("reset mem_wdata", mem_wdata, 64'd0);
      check("reset rsp_rdata", rsp_rdata, 64'd0);
      rst_n = 1'b1;

      // Directed accesses around the preloaded doubleword at 0x10
      issue(1'b0, 2'b00, 1'b0, 10'h017, 64'd0, 1'b1);
      issue(1'b0, 2'b01, 1'b1, 10'h016, 64'd0, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 10'h014, 64'd0, 1'b1);
      issue(1'b1, 2'b00, 1'b0, 10'h011, 64'hAB, 1'b1);
      issue(1'b0, 2'b11, 1'b0, 10'h010, 64'd0, 1'b1);
      issue(1'b1, 2'b11, 1'b0, 10'h018, 64'h0123456789ABCDEF, 1'b1);
      issue(1'b0, 2'b11, 1'b1, 10'h018, 64'd0, 1'b1);
      issue(1'b0, 2'b01, 1'b0, 10'h013, 64'd0, 1'b1);
      wait_idle();

      // Reset during WAIT of a sub-doubleword store aborts it
      wr_before = tot_wr;
      issue(1'b1, 2'b00, 1'b0, 10'h012, 64'h5A, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk); #1;
      check("abort req_ready in reset", {63'd0, req_ready}, 64'd0);
      check("abort mem_write", {63'd0, mem_write}, 64'd0);
      check("abort rsp_valid", {63'd0, rsp_valid}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("abort req_ready after", {63'd0, req_ready}, 64'd1);
      check("abort no write", 64'(tot_wr), 64'(wr_before));
      check("abort memory unchanged", dmem[2], ref_dword(16));

      // Randomised traffic, mostly aligned, with random idle gaps
      for (int t = 0; t < 300; t++) begin
         sz = 2'($urandom_range(0, 3));
         n  = 1 << sz;
         a  = int'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) a = a & ~(n - 1);
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), 10'(a),
               {$urandom, $urandom}, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();

      for (int w = 0; w < 128; w++) check("memory image", dmem[w], ref_dword(w * 8));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      miscompares++;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule
